// File: rtl/tx_package.sv
// NMEA sentence transmitter: buffers a host payload, then streams SOF, payload,
// optional "*HH" checksum and EOF bytes to a UART TX over valid/ready.
module tx_package #(
    parameter int          SOF_LENGTH  = 6,
    parameter logic [47:0] SOF_PATTERN = 48'h244750474741,
    parameter int          PAYLOAD_MAX = 128,
    parameter bit          CHECKSUM_EN = 1'b1,
    parameter int          EOF_LENGTH  = 2,
    parameter logic [31:0] EOF_PATTERN = 32'h00000D0A
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        enable_i,
    input  logic        wr_en_i,
    input  logic [7:0]  wr_data_i,
    input  logic        start_i,
    input  logic        tx_ready_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_datavld_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic [10:0] frame_cnt_o,
    output logic        wr_err_o
);

    localparam int         AW       = (PAYLOAD_MAX > 1) ? $clog2(PAYLOAD_MAX) : 1;
    localparam logic [7:0] MAX_CNT  = 8'(PAYLOAD_MAX);
    localparam logic [7:0] SOF_LAST = 8'(SOF_LENGTH - 1);
    localparam logic [7:0] EOF_LAST = 8'(EOF_LENGTH - 1);

    typedef enum logic [2:0] {
        IDLE, SOF, PAYLOAD, CKS_STAR, CKS_HI, CKS_LO, EOF, DONE
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  idx, idx_nxt;
    logic [7:0]  count;
    logic [7:0]  cks;
    logic [7:0]  byte_out;
    logic [10:0] frame_cnt;
    logic        wr_err;
    logic        xfer;
    logic        wr_ok;
    logic [7:0]  mem [PAYLOAD_MAX];

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] sof_byte(input logic [7:0] i);
        return 8'(SOF_PATTERN >> (8 * (SOF_LENGTH - 1 - int'(i))));
    endfunction

    function automatic logic [7:0] eof_byte(input logic [7:0] i);
        return 8'(EOF_PATTERN >> (8 * (EOF_LENGTH - 1 - int'(i))));
    endfunction

    assign xfer  = tx_datavld_o && tx_ready_i && enable_i;
    assign wr_ok = wr_en_i && (state == IDLE) && (count < MAX_CNT);

    // Presented byte depends only on state/index, so it is inherently stable until accepted
    always_comb begin
        byte_out = 8'h00;
        case (state)
            SOF:      byte_out = sof_byte(idx);
            PAYLOAD:  byte_out = mem[idx[AW-1:0]];
            CKS_STAR: byte_out = 8'h2A;
            CKS_HI:   byte_out = hex_ascii(cks[7:4]);
            CKS_LO:   byte_out = hex_ascii(cks[3:0]);
            EOF:      byte_out = eof_byte(idx);
            default:  byte_out = 8'h00;
        endcase
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (start_i && enable_i) begin
                    state_nxt = SOF;
                    idx_nxt   = 8'd0;
                end
            end
            SOF: begin
                if (xfer) begin
                    if (idx == SOF_LAST) begin
                        idx_nxt = 8'd0;
                        if (count == 8'd0)
                            state_nxt = CHECKSUM_EN ? CKS_STAR : EOF;
                        else
                            state_nxt = PAYLOAD;
                    end else begin
                        idx_nxt = idx + 8'd1;
                    end
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    if (idx == count - 8'd1) begin
                        idx_nxt   = 8'd0;
                        state_nxt = CHECKSUM_EN ? CKS_STAR : EOF;
                    end else begin
                        idx_nxt = idx + 8'd1;
                    end
                end
            end
            CKS_STAR: if (xfer) state_nxt = CKS_HI;
            CKS_HI:   if (xfer) state_nxt = CKS_LO;
            CKS_LO: begin
                if (xfer) begin
                    state_nxt = EOF;
                    idx_nxt   = 8'd0;
                end
            end
            EOF: begin
                if (xfer) begin
                    if (idx == EOF_LAST) begin
                        idx_nxt   = 8'd0;
                        state_nxt = DONE;
                    end else begin
                        idx_nxt = idx + 8'd1;
                    end
                end
            end
            DONE:    if (enable_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state     <= IDLE;
            idx       <= 8'd0;
            count     <= 8'd0;
            cks       <= 8'd0;
            frame_cnt <= 11'd0;
            wr_err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            wr_err <= wr_en_i && !wr_ok;
            if (wr_ok)
                count <= count + 8'd1;
            else if (state == DONE && enable_i)
                count <= 8'd0;
            // The leading SOF byte is excluded from the NMEA checksum
            if (state == IDLE)
                cks <= 8'd0;
            else if (xfer && ((state == SOF && idx != 8'd0) || state == PAYLOAD))
                cks <= cks ^ byte_out;
            if (state == DONE && enable_i)
                frame_cnt <= frame_cnt + 11'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok)
            mem[count[AW-1:0]] <= wr_data_i;
    end

    assign tx_data_o    = byte_out;
    assign tx_datavld_o = (state != IDLE) && (state != DONE);
    assign busy_o       = (state != IDLE);
    assign frame_done_o = (state == DONE);
    assign frame_cnt_o  = frame_cnt;
    assign wr_err_o     = wr_err;

endmodule

// File: tb/tb_tx_package.sv
// Directed bench for tx_package: table of frames plus hand-written sequences
// for overflow, write-while-busy, enable freeze, no-checksum build and async reset.
module tb_tx_package;

    logic        clk = 1'b0;
    logic        rst_n, enable, wr_en, start, tx_ready;
    logic [7:0]  wr_data;
    logic [7:0]  tx_data;
    logic        tx_vld, busy, done, wr_err;
    logic [10:0] cnt;

    logic        nc_start, nc_wr_en;
    logic [7:0]  nc_data;
    logic        nc_vld, nc_busy, nc_done, nc_err;
    logic [10:0] nc_cnt;

    logic        sel;
    logic [7:0]  s_data;
    logic        s_vld, s_busy, s_done, s_err;
    logic [10:0] s_cnt;

    int npass = 0;
    int ntotal = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        int          npay;
        logic [31:0] pay;
        bit          same;
        bit          toggle;
        int          nexp;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    tx_package dut (
        .clk_i(clk), .reset_n_i(rst_n), .enable_i(enable), .wr_en_i(wr_en),
        .wr_data_i(wr_data), .start_i(start), .tx_ready_i(tx_ready),
        .tx_data_o(tx_data), .tx_datavld_o(tx_vld), .busy_o(busy),
        .frame_done_o(done), .frame_cnt_o(cnt), .wr_err_o(wr_err)
    );

    tx_package #(.CHECKSUM_EN(1'b0)) dut_nc (
        .clk_i(clk), .reset_n_i(rst_n), .enable_i(enable), .wr_en_i(nc_wr_en),
        .wr_data_i(wr_data), .start_i(nc_start), .tx_ready_i(tx_ready),
        .tx_data_o(nc_data), .tx_datavld_o(nc_vld), .busy_o(nc_busy),
        .frame_done_o(nc_done), .frame_cnt_o(nc_cnt), .wr_err_o(nc_err)
    );

    assign s_data = sel ? nc_data : tx_data;
    assign s_vld  = sel ? nc_vld  : tx_vld;
    assign s_busy = sel ? nc_busy : busy;
    assign s_done = sel ? nc_done : done;
    assign s_err  = sel ? nc_err  : wr_err;
    assign s_cnt  = sel ? nc_cnt  : cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_str(input logic [127:0] s, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(s[(n-1-i)*8 +: 8]);
    endtask

    task automatic write_bytes(input int n, input logic [31:0] pay, input bit same);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = pay[(n-1-i)*8 +: 8];
            start   = same && (i == n - 1);
        end
        @(negedge clk);
        wr_en = 1'b0;
        start = 1'b0;
    endtask

    task automatic send_start(input bit nc);
        @(negedge clk);
        if (nc) nc_start = 1'b1;
        else    start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        nc_start = 1'b0;
    endtask

    // Entered at the negedge following the start edge; collects accepted bytes.
    task automatic capture(input bit toggle, input int freeze_at, input bit wr_busy, input int exp_cnt);
        logic [7:0] got[$];
        logic [7:0] pend_data;
        bit pend, fin;
        int frz, fin_cyc;
        pend = 0; fin = 0; frz = 0; fin_cyc = -1; pend_data = 8'h00;
        for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
            tx_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            enable   = 1'b1;
            if (freeze_at >= 0 && got.size() == freeze_at && frz < 5) begin
                enable = 1'b0;
                frz++;
            end
            wr_en   = wr_busy && (cyc == 3);
            wr_data = 8'h55;
            #1;
            if (cyc == 0) chk("first_byte_latency", 32'({s_vld, s_data}), 32'({1'b1, 8'h24}));
            if (wr_busy && cyc == 4) chk("wr_err_busy", 32'(s_err), 32'd1);
            if (!enable) chk("freeze_valid", 32'(s_vld), 32'd1);
            if (s_done) begin
                fin = 1;
                fin_cyc = cyc;
            end else if (s_vld) begin
                if (pend) chk("hold_stable", 32'(s_data), 32'(pend_data));
                if (tx_ready && enable) begin
                    got.push_back(s_data);
                    pend = 0;
                end else begin
                    pend = 1;
                    pend_data = s_data;
                end
            end
            if (!fin) @(negedge clk);
        end
        wr_en = 1'b0;
        chk("frame_done_seen", 32'(fin), 32'd1);
        if (!toggle && freeze_at < 0) chk("back_to_back_cycles", fin_cyc, exp_q.size());
        chk("byte_count", got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("byte%0d", i), 32'(got[i]), 32'(exp_q[i]));
        @(negedge clk);
        #1;
        chk("done_one_cycle", 32'(s_done), 32'd0);
        chk("idle_after_done", 32'(s_busy), 32'd0);
        chk("frame_cnt", 32'(s_cnt), exp_cnt);
        tx_ready = 1'b0;
    endtask

    initial begin
        int frames, errs;
        rst_n = 1'b0; enable = 1'b1; wr_en = 1'b0; wr_data = 8'h00; start = 1'b0;
        tx_ready = 1'b0; nc_start = 1'b0; nc_wr_en = 1'b0; sel = 1'b0;
        frames = 0;

        vecs[0] = '{0, 32'h0,      1'b0, 1'b0, 11, {40'h0, "$GPGGA*56\r\n"}};
        vecs[1] = '{2, 32'h2C31,   1'b1, 1'b0, 13, {24'h0, "$GPGGA,1*4B\r\n"}};
        vecs[2] = '{2, 32'h2C31,   1'b0, 1'b1, 13, {24'h0, "$GPGGA,1*4B\r\n"}};
        vecs[3] = '{1, 32'h41,     1'b0, 1'b0, 12, {32'h0, "$GPGGAA*17\r\n"}};
        vecs[4] = '{1, 32'hFC,     1'b0, 1'b0, 12, {32'h0, "$GPGGA", 8'hFC, "*AA\r\n"}};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_vld", 32'(tx_vld), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_wr_err", 32'(wr_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[v]) begin
            exp_q.delete();
            push_str(vecs[v].exp, vecs[v].nexp);
            if (vecs[v].npay > 0) write_bytes(vecs[v].npay, vecs[v].pay, vecs[v].same);
            if (!vecs[v].same) send_start(1'b0);
            frames++;
            capture(vecs[v].toggle, -1, 1'b0, frames);
        end

        // Fill buffer, then one extra write must be dropped
        errs = 0;
        for (int i = 0; i < 129; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = 8'h30;
            #1;
            if (i > 0 && wr_err) errs++;
        end
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        chk("no_err_until_full", errs, 0);
        chk("wr_err_full", 32'(wr_err), 32'd1);
        @(negedge clk);
        #1;
        chk("wr_err_single_pulse", 32'(wr_err), 32'd0);
        exp_q.delete();
        push_str({80'h0, "$GPGGA"}, 6);
        for (int i = 0; i < 128; i++) exp_q.push_back(8'h30);
        push_str({88'h0, "*56\r\n"}, 5);
        send_start(1'b0);
        frames++;
        capture(1'b0, -1, 1'b1, frames);

        exp_q.delete();
        push_str({40'h0, "$GPGGA*56\r\n"}, 11);
        send_start(1'b0);
        frames++;
        capture(1'b0, 3, 1'b0, frames);

        sel = 1'b1;
        exp_q.delete();
        push_str({64'h0, "$GPGGA\r\n"}, 8);
        send_start(1'b1);
        capture(1'b0, -1, 1'b0, 1);
        sel = 1'b0;

        // Abort mid-payload with an asynchronous reset
        write_bytes(4, 32'h41424344, 1'b0);
        send_start(1'b0);
        tx_ready = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk("mid_payload_byte", 32'({tx_vld, tx_data}), 32'({1'b1, 8'h43}));
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_vld", 32'(tx_vld), 32'd0);
        chk("async_rst_data", 32'(tx_data), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_cnt", 32'(cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tx_ready = 1'b0;
        exp_q.delete();
        push_str({40'h0, "$GPGGA*56\r\n"}, 11);
        send_start(1'b0);
        capture(1'b0, -1, 1'b0, 1);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/tx_package.md
Name: tx_package

Overview:
Transmit-side counterpart of the NMEA frame receiver/packager. It buffers a payload written by the host, then on a start command emits a complete sentence byte by byte to a UART transmitter over a valid/ready handshake. The sentence is SOF pattern ("$GPGGA"), payload, optional "*HH" checksum, then EOF pattern ("\r\n"). It sits between the payload producer (CPU/register block) and the UART TX byte interface.

Parameters:
SOF_LENGTH, 6, number of SOF bytes (1..6)
SOF_PATTERN, 48'h244750474741, SOF bytes, MSB byte sent first ("$GPGGA")
PAYLOAD_MAX, 128, payload buffer depth in bytes (1..255)
CHECKSUM_EN, 1'b1, 1 = insert '*', hi hex, lo hex before EOF
EOF_LENGTH, 2, number of EOF bytes (1..4)
EOF_PATTERN, 32'h00000D0A, EOF bytes, right-aligned, MSB-first of used bytes ("\r\n")

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
enable_i  in  1  1 = FSM advances; 0 = FSM and handshake frozen
wr_en_i  in  1  payload byte write strobe
wr_data_i  in  8  payload byte
start_i  in  1  single-cycle request to transmit buffered frame
tx_ready_i  in  1  UART TX can accept a byte this cycle
tx_data_o  out  8  byte to UART
tx_datavld_o  out  1  tx_data_o valid
busy_o  out  1  frame transmission in progress
frame_done_o  out  1  one-cycle pulse after last EOF byte accepted
frame_cnt_o  out  11  frames completed, wraps at 2047
wr_err_o  out  1  one-cycle pulse: write dropped (busy or buffer full)

Behaviour:
- Reset: all outputs 0, payload count 0, checksum 0, FSM IDLE. Reset mid-frame aborts immediately; buffer contents discarded (count 0).
- Buffer: writes accepted only in IDLE with count < PAYLOAD_MAX: mem[count] <= wr_data_i, count++. Write in non-IDLE or count == PAYLOAD_MAX: dropped, wr_err_o pulses next cycle. Writes are independent of enable_i.
- States: IDLE, SOF, PAYLOAD, CKS_STAR, CKS_HI, CKS_LO, EOF, DONE.
- IDLE -> SOF when start_i && enable_i; tx_datavld_o=1 with '$' (first SOF byte) on the next cycle (latency 1). start_i in any other state ignored. start_i in the same cycle as wr_en_i: write accepted, included in frame.
- Transfer occurs on a rising edge where tx_datavld_o && tx_ready_i && enable_i. tx_data_o is stable while valid and not accepted. After a transfer, next byte is presented the following cycle (valid may stay high; back-to-back one byte/cycle when tx_ready_i held high).
- SOF: SOF_LENGTH bytes -> PAYLOAD (or, if count == 0, directly -> CKS_STAR / EOF per CHECKSUM_EN). PAYLOAD: mem[0..count-1] -> CKS_STAR if CHECKSUM_EN else EOF. CKS_STAR: '*' (8'h2A). CKS_HI/CKS_LO: hex ASCII of checksum upper/lower nibble; nibble 0-9 -> 8'h30+n, A-F -> 8'h37+n (uppercase). EOF: EOF_LENGTH bytes -> DONE.
- Checksum: 8-bit XOR of every byte sent after the first SOF byte up to but excluding '*'; cleared in IDLE; updated on each accepted SOF(≠first)/PAYLOAD byte.
- DONE (one cycle, tx_datavld_o=0): frame_done_o=1, frame_cnt_o++ (wrap 2047->0), count cleared -> IDLE.
- busy_o=1 in every state except IDLE.
- enable_i=0: no state change, no transfer, tx_data_o/tx_datavld_o hold; resumes unchanged when enable_i returns.

Test Plan:
- Empty payload, CHECKSUM_EN=1, tx_ready_i=1: start_i -> 11 bytes "$GPGGA*56\r\n" (24 47 50 47 47 41 2A 35 36 0D 0A) on consecutive cycles, frame_done_o pulse, frame_cnt_o=1.
- Write 2C,31 then start -> "$GPGGA,1*4B\r\n" (13 bytes); checksum 0x4B; count 0 after DONE.
- tx_ready_i toggling 1/0 each cycle -> same byte stream, each byte held stable ≥2 cycles, no duplicates/drops.
- Write PAYLOAD_MAX+1 bytes -> last write dropped, wr_err_o single pulse; write during busy -> wr_err_o pulse, frame unchanged.
- CHECKSUM_EN=0, empty payload -> 8 bytes "$GPGGA\r\n"; enable_i low for 5 cycles mid-SOF -> output frozen, stream completes correctly after.
- Reset asserted during PAYLOAD -> all outputs 0 asynchronously; new start with empty buffer -> "$GPGGA*56\r\n", frame_cnt_o=1.
